router_pkt_tx: RTL
==================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the 1x3 router input port: drives data_in/pkt_valid and obeys busy.
//  Accepts a command (destination addr, payload length) plus payload bytes from a local producer.
//  Buffers the whole payload before transmission, because pkt_valid must not drop mid-packet.
//  Emits header {len[5:0],addr[1:0]}, then payload, then parity = XOR of header and all payload bytes.
// PARAMETERS
//  MAX_LEN     63  largest legal payload length; must be 1..63.
//  GAP_CYCLES  2   minimum idle cycles between the parity byte and the next header.
// PORTS
//  clock           in   1  single clock, rising edge.
//  reset           in   1  synchronous, active-high.
//  cmd_valid       in   1  command valid.
//  cmd_ready       out  1  command accepted on any edge where cmd_valid & cmd_ready.
//  cmd_addr        in   2  destination port 0..2; 3 is illegal.
//  cmd_len         in   6  payload length; legal range 1..MAX_LEN.
//  cmd_bad_parity  in   1  transmit the parity byte with bit0 inverted (error injection).
//  pay_valid       in   1  payload byte valid.
//  pay_ready       out  1  payload byte accepted on any edge where pay_valid & pay_ready.
//  pay_data        in   8  payload byte.
//  busy            in   1  router busy; the current byte is held while busy is high.
//  pkt_valid       out  1  high for header and payload bytes; low for the parity byte.
//  data_out        out  8  byte to router data_in; registered.
//  tx_done         out  1  1-cycle pulse when the parity byte is consumed.
//  cmd_err         out  1  1-cycle pulse when a command is rejected.
// BEHAVIOUR
//  Reset: state=IDLE; pkt_valid, data_out, tx_done, cmd_err, counters and parity all 0.
//   Buffer contents are not cleared.
//   cmd_ready and pay_ready are decoded from state and forced 0 while reset is high.
//  Reset mid-operation: the next edge returns to IDLE with pkt_valid=0 and data_out=0.
//   The partial packet is abandoned.
//  Consumption rule: the byte on data_out is consumed on an edge where busy==0.
//   While busy==1, data_out and pkt_valid hold stable.
//  IDLE: cmd_ready=1.
//   On accept with addr==3, len==0 or len>MAX_LEN: pulse cmd_err and stay in IDLE.
//   On accept otherwise: latch addr, len and bad_parity; parity={len,addr}; cnt=0; go to LOAD.
//  LOAD: pay_ready=1.
//   Each accept writes buf[cnt], sets parity^=pay_data and increments cnt.
//   Gaps in pay_valid are allowed.
//   On accept of byte len-1: data_out<={len,addr}, pkt_valid<=1, idx=0, go to HEADER.
//  HEADER: on consume, data_out<=buf[0] and go to PAYLOAD.
//  PAYLOAD: on consume of buf[idx]:
//   if idx<len-1: idx++ and data_out<=buf[idx+1];
//   else: pkt_valid<=0, data_out<=parity^{7'b0,bad_parity}, go to PARITY.
//  PARITY: on consume: pulse tx_done, data_out<=0, gap counter=0, go to GAP.
//  GAP: count GAP_CYCLES cycles; then go to IDLE on the first cycle with busy==0.
//  Ignored inputs: cmd_valid outside IDLE (cmd_ready=0); pay_valid outside LOAD (pay_ready=0).
//   busy is don't-care in IDLE and LOAD.
//  Widths: cnt and idx are 6-bit and never exceed len-1.
//   A packet occupies exactly len+2 consumed bytes.
//  Latency with busy==0 throughout: header appears 1 edge after the last payload accept.
//   One byte per cycle after that; tx_done is len+2 edges after the header appears.
// STRUCTURE
//  Shared package router_pkg holds:
//   - tx_state_e {IDLE,LOAD,HEADER,PAYLOAD,PARITY,GAP};
//   - ADDR_INVALID=2'b11, LEN_W=6;
//   - header field positions (len [7:2], addr [1:0]).
//  Sub-module router_tx_buf: MAX_LEN x 8 register array, synchronous write, asynchronous read.
//  FSM, counters and parity accumulator live in router_pkt_tx.
// TESTING
//  1. addr=0, len=3, payload 11,22,33, busy=0 -> data_out 0C,11,22,33 with pkt_valid=1;
//     then 0C with pkt_valid=0; tx_done pulses once.
//  2. As test 1 with busy=1 for 5 cycles after the header appears -> header held 6 cycles;
//     payload then follows with no byte skipped or repeated.
//  3. cmd_addr=3 (then cmd_len=0) -> cmd_err pulses, pay_ready stays 0, pkt_valid stays 0.
//  4. addr=2, len=63, payload 00..3E with random pay_valid gaps -> header FE;
//     63 ordered bytes; parity matches the reference XOR.
//  5. Test 1 with cmd_bad_parity=1 -> parity byte 0D; all other bytes unchanged.
//  6. reset pulsed during PAYLOAD -> next edge pkt_valid=0, data_out=00;
//     cmd_ready=1 once reset is low; the next packet is sent correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

    localparam int unsigned LEN_W        = 6;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_e;

    function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                               input logic [1:0]       addr);
        logic [7:0] hdr;
        hdr                            = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Command, payload and router-side signals of the packet transmitter.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_bad_parity;
    logic             pay_valid;
    logic             pay_ready;
    logic [7:0]       pay_data;
    logic             busy;
    logic             pkt_valid;
    logic [7:0]       data_out;
    logic             tx_done;
    logic             cmd_err;

    // master is the transmitter itself; slave is the producer/router environment.
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_bad_parity,
        input  pay_valid, pay_data, busy,
        output cmd_ready, pay_ready, pkt_valid, data_out, tx_done, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_bad_parity,
        output pay_valid, pay_data, busy,
        input  cmd_ready, pay_ready, pkt_valid, data_out, tx_done, cmd_err
    );

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer: register array with synchronous write and asynchronous read.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 63,
    parameter int unsigned AW    = LEN_W
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers a whole packet, then streams header, payload and parity to the router input port.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    router_pkt_tx_if.master tx
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e        state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             badp_q, badp_d;
    logic [7:0]       parity_q, parity_d;
    logic [7:0]       data_q, data_d;
    logic             pv_q, pv_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             cmd_fire, pay_fire, consume, cmd_bad, gap_done;
    logic [LEN_W-1:0] rd_addr;
    logic [7:0]       rd_data;

    assign tx.cmd_ready = (state_q == IDLE) && !reset;
    assign tx.pay_ready = (state_q == LOAD) && !reset;
    assign tx.pkt_valid = pv_q;
    assign tx.data_out  = data_q;
    assign tx.tx_done   = done_q;
    assign tx.cmd_err   = err_q;

    assign cmd_fire = tx.cmd_valid && tx.cmd_ready;
    assign pay_fire = tx.pay_valid && tx.pay_ready;
    assign consume  = !tx.busy;
    assign cmd_bad  = (tx.cmd_addr == ADDR_INVALID) || (tx.cmd_len == '0) ||
                      (32'(tx.cmd_len) > MAX_LEN);
    assign gap_done = (32'(gap_q) + 32'd1) >= GAP_CYCLES;
    // Prefetch the byte after the one on data_out so it can be loaded on consume.
    assign rd_addr  = (state_q == PAYLOAD) ? idx_q + 1'b1 : '0;

    router_tx_buf #(.DEPTH(MAX_LEN), .AW(LEN_W)) u_buf (
        .clock (clock),
        .we    (pay_fire),
        .waddr (cnt_q),
        .wdata (tx.pay_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            badp_q   <= 1'b0;
            parity_q <= '0;
            data_q   <= '0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            badp_q   <= badp_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        badp_d   = badp_q;
        parity_d = parity_q;
        data_d   = data_q;
        pv_d     = pv_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = tx.cmd_addr;
                        len_d    = tx.cmd_len;
                        badp_d   = tx.cmd_bad_parity;
                        parity_d = make_header(tx.cmd_len, tx.cmd_addr);
                        cnt_d    = '0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pay_fire) begin
                    parity_d = parity_q ^ tx.pay_data;
                    if (cnt_q == len_q - 1'b1) begin
                        data_d  = make_header(len_q, addr_q);
                        pv_d    = 1'b1;
                        idx_d   = '0;
                        state_d = HEADER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HEADER: begin
                if (consume) begin
                    data_d  = rd_data;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (consume) begin
                    if (idx_q < len_q - 1'b1) begin
                        idx_d  = idx_q + 1'b1;
                        data_d = rd_data;
                    end else begin
                        pv_d    = 1'b0;
                        data_d  = parity_q ^ {7'b0, badp_q};
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (consume) begin
                    done_d  = 1'b1;
                    data_d  = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!gap_done) begin
                    gap_d = gap_q + 1'b1;
                end else if (consume) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
